// File: rtl/mem_pkg.sv
// Shared defaults, request payload type and width helper for the memory arbiter slice.
package mem_pkg;

  localparam int unsigned DEF_AW    = 24;
  localparam int unsigned DEF_DW    = 16;
  localparam int unsigned DEF_BURST = 4;

  typedef struct packed {
    logic              we;
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] wdata;
  } mem_req_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_id_fifo.sv
// Synchronous FIFO of requester IDs; one entry per outstanding read burst.
module mem_id_fifo
  import mem_pkg::*;
#(
  parameter int unsigned IW    = 2,
  parameter int unsigned TAG_N = 2
) (
  input  logic          clkSYS,
  input  logic          n_reset,
  input  logic          push,
  input  logic          pop,
  input  logic [IW-1:0] din,
  output logic [IW-1:0] head,
  output logic          empty,
  output logic          full
);

  localparam int unsigned DEPTH = 2 ** TAG_N;
  localparam int unsigned CW    = TAG_N + 1;

  logic [IW-1:0]    mem [DEPTH];
  logic [TAG_N-1:0] wr_ptr;
  logic [TAG_N-1:0] rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];

  always_ff @(posedge clkSYS) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + TAG_N'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + TAG_N'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates N requesters onto one memory port; burst read data is routed back in order via an ID FIFO.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned BURST = DEF_BURST,
  parameter int unsigned TAG_N = 2,
  parameter bit          PRIO0 = 1'b1
) (
  input  logic            clkSYS,
  input  logic            n_reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    we,
  input  logic [N*AW-1:0] addr,
  input  logic [N*DW-1:0] wdata,
  output logic [N-1:0]    rdy,
  output logic [N-1:0]    ifrdy,
  output logic [DW-1:0]   rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_rdy,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            err
);

  localparam int unsigned IW = (clog2(N) > 0) ? clog2(N) : 1;
  localparam int unsigned CW = (clog2(BURST) > 0) ? clog2(BURST) : 1;

  logic [IW-1:0] rr_ptr;
  logic [CW-1:0] beat_cnt;
  logic [IW-1:0] fifo_head;
  logic          fifo_empty;
  logic          fifo_full;
  logic          beat_ok;
  logic          last_beat;
  logic          blocked;
  logic [N-1:0]  eligible;
  logic          grant_vld;
  logic [IW-1:0] grant_idx;
  logic          accept;
  logic          push;

  // Return path: beats are only meaningful while a burst is outstanding.
  always_comb begin
    beat_ok   = mem_rvalid & ~fifo_empty;
    last_beat = beat_ok & (beat_cnt == CW'(BURST - 1));
    blocked   = fifo_full & ~last_beat;
    for (int i = 0; i < N; i++) begin
      eligible[i] = req[i] & (we[i] | ~blocked);
    end
  end

  // Requester 0 may pre-empt; otherwise scan from rr_ptr with wrap.
  always_comb begin : p_grant
    int unsigned idx;
    logic [IW-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    cand      = '0;
    if (PRIO0 && eligible[0]) begin
      grant_vld = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N) idx = idx - N;
        cand = IW'(idx);
        if (!grant_vld && eligible[cand] && !(PRIO0 && idx == 0)) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    mem_req   = grant_vld;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rdy       = '0;
    ifrdy     = '0;
    rdata     = beat_ok ? mem_rdata : '0;
    for (int i = 0; i < N; i++) begin
      if (grant_vld && grant_idx == IW'(i)) begin
        mem_we    = we[i];
        mem_addr  = addr[i*AW +: AW];
        mem_wdata = wdata[i*DW +: DW];
        rdy[i]    = mem_rdy;
      end
      ifrdy[i] = beat_ok & (fifo_head == IW'(i));
    end
    accept = grant_vld & mem_rdy;
    push   = accept & ~mem_we;
  end

  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      rr_ptr   <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        if (grant_idx == IW'(N - 1)) rr_ptr <= PRIO0 ? IW'(1) : IW'(0);
        else                         rr_ptr <= grant_idx + IW'(1);
      end
      if (beat_ok) beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
      if (mem_rvalid && fifo_empty) err <= 1'b1;
    end
  end

  mem_id_fifo #(
    .IW    (IW),
    .TAG_N (TAG_N)
  ) u_id_fifo (
    .clkSYS  (clkSYS),
    .n_reset (n_reset),
    .push    (push),
    .pop     (last_beat),
    .din     (grant_idx),
    .head    (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

endmodule
